irq_responder: RTL and testbench

- CPU-side receiving end of the PIC interrupt interface inside hunter_RV32.
- Consumes the PIC's INT/INT_NUM and the external NMI pin, and synchronizes them.
- Arbitrates NMI over maskable interrupts and presents one trap request, with vector and cause, to the pipeline.
- Tracks in-service state until the pipeline signals trap return; supports a single NMI nesting over a maskable handler.

---
 rtl/irq_responder_if.sv | 22 ++
 rtl/irq_responder.sv | 78 +++++++
 tb/tb_irq_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_responder_if.sv
// irq_responder_if: PIC/NMI inputs and pipeline trap handshake for the interrupt responder
interface irq_responder_if;
    logic        NMI;
    logic        INT;
    logic [2:0]  INT_NUM;
    logic        int_en;
    logic        trap_ack;
    logic        trap_ret;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic [3:0]  trap_cause;
    logic        in_service;
    logic        nmi_active;
    modport master (
        output NMI, INT, INT_NUM, int_en, trap_ack, trap_ret,
        input  trap_req, trap_vec, trap_cause, in_service, nmi_active
    );
    modport slave (
        input  NMI, INT, INT_NUM, int_en, trap_ack, trap_ret,
        output trap_req, trap_vec, trap_cause, in_service, nmi_active
    );
endinterface

// File: rtl/irq_responder.sv
// irq_responder: synchronizes PIC INT/INT_NUM and NMI, arbitrates NMI first, tracks in-service state
module irq_responder #(
    parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
    parameter int          VEC_SHIFT   = 2,
    parameter logic [31:0] NMI_VEC     = 32'h0000_0080,
    parameter int          SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           rst,
    irq_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, SVC, NMI_REQ, NMI_SVC} state_t;
    state_t                          state, nxt;
    logic [SYNC_STAGES-1:0]          nmi_sync, int_sync;
    logic [SYNC_STAGES-1:0][2:0]     num_sync;
    logic                            nmi_s, int_s, nmi_d, nmi_rise, nmi_pending;
    logic [2:0]                      num_s, num_q, num_n;
    logic                            saved_int, saved_n;
    logic                            trap_req, in_service, nmi_active;
    logic [31:0]                     trap_vec;
    logic [3:0]                      trap_cause;
    assign nmi_s    = nmi_sync[SYNC_STAGES-1];
    assign int_s    = int_sync[SYNC_STAGES-1];
    assign num_s    = num_sync[SYNC_STAGES-1];
    assign nmi_rise = nmi_s & ~nmi_d;
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = nmi_pending ? NMI_REQ : (int_s && bus.int_en) ? REQ : IDLE;
            REQ:     nxt = bus.trap_ack ? SVC : nmi_pending ? NMI_REQ : (!int_s || !bus.int_en) ? IDLE : REQ;
            SVC:     nxt = bus.trap_ret ? IDLE : nmi_pending ? NMI_REQ : SVC;
            NMI_REQ: nxt = bus.trap_ack ? NMI_SVC : NMI_REQ;
            NMI_SVC: nxt = !bus.trap_ret ? NMI_SVC : nmi_pending ? NMI_REQ : saved_int ? SVC : IDLE;
            default: nxt = IDLE;
        endcase
    end
    // saved_int remembers a maskable handler preempted by NMI so the NMI return resumes it
    assign saved_n = (state == SVC && nxt == NMI_REQ) ? 1'b1 :
                     (state == NMI_SVC && nxt == SVC) ? 1'b0 : saved_int;
    assign num_n   = (state == IDLE && nxt == REQ) ? num_s : num_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nmi_sync    <= '0;
            int_sync    <= '0;
            num_sync    <= '0;
            nmi_d       <= 1'b0;
            nmi_pending <= 1'b0;
            state       <= IDLE;
            saved_int   <= 1'b0;
            num_q       <= '0;
            trap_req    <= 1'b0;
            trap_vec    <= '0;
            trap_cause  <= '0;
            in_service  <= 1'b0;
            nmi_active  <= 1'b0;
        end else begin
            nmi_sync    <= {nmi_sync[SYNC_STAGES-2:0], bus.NMI};
            int_sync    <= {int_sync[SYNC_STAGES-2:0], bus.INT};
            num_sync    <= {num_sync[SYNC_STAGES-2:0], bus.INT_NUM};
            nmi_d       <= nmi_s;
            nmi_pending <= nmi_rise | (nmi_pending & ~(state == NMI_REQ && bus.trap_ack));
            state       <= nxt;
            saved_int   <= saved_n;
            num_q       <= num_n;
            trap_req    <= nxt == REQ || nxt == NMI_REQ;
            trap_vec    <= nxt == NMI_REQ ? NMI_VEC :
                           nxt == REQ ? VEC_BASE + (32'(num_n) << VEC_SHIFT) : '0;
            trap_cause  <= nxt == NMI_REQ ? 4'hF : nxt == REQ ? {1'b0, num_n} : 4'h0;
            in_service  <= nxt == SVC || nxt == NMI_SVC || (nxt == NMI_REQ && saved_n);
            nmi_active  <= nxt == NMI_SVC;
        end
    end
    assign bus.trap_req   = trap_req;
    assign bus.trap_vec   = trap_vec;
    assign bus.trap_cause = trap_cause;
    assign bus.in_service = in_service;
    assign bus.nmi_active = nmi_active;
endmodule

// File: tb/tb_irq_responder.sv
// tb_irq_responder: directed vectors with hand-computed expectations for irq_responder
module tb_irq_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic seen;
    irq_responder_if bus();
    irq_responder dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic ack();
        bus.trap_ack = 1'b1;
        step(1);
        bus.trap_ack = 1'b0;
    endtask
    task automatic ret();
        bus.trap_ret = 1'b1;
        step(1);
        bus.trap_ret = 1'b0;
    endtask
    initial begin
        bus.NMI = 0; bus.INT = 0; bus.INT_NUM = 0; bus.int_en = 0;
        bus.trap_ack = 0; bus.trap_ret = 0;
        step(3);
        chk("rst_req", 32'(bus.trap_req), 0);
        chk("rst_vec", bus.trap_vec, 0);
        chk("rst_cause", 32'(bus.trap_cause), 0);
        chk("rst_svc", 32'(bus.in_service), 0);
        chk("rst_nmi", 32'(bus.nmi_active), 0);
        rst = 1'b1;
        step(2);
        // IRQ5 basic flow: request appears on the third edge
        bus.INT = 1; bus.INT_NUM = 5; bus.int_en = 1;
        step(2);
        chk("irq5_early", 32'(bus.trap_req), 0);
        step(1);
        chk("irq5_req", 32'(bus.trap_req), 1);
        chk("irq5_vec", bus.trap_vec, 32'h114);
        chk("irq5_cause", 32'(bus.trap_cause), 5);
        bus.INT = 0;
        ack();
        chk("irq5_ack_req", 32'(bus.trap_req), 0);
        chk("irq5_svc", 32'(bus.in_service), 1);
        step(3);
        ret();
        chk("irq5_ret", 32'(bus.in_service), 0);
        step(3);
        // masked IRQ2 then enable
        bus.INT = 1; bus.INT_NUM = 2; bus.int_en = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            seen |= bus.trap_req;
        end
        chk("masked", 32'(seen), 0);
        bus.int_en = 1;
        step(1);
        chk("irq2_req", 32'(bus.trap_req), 1);
        chk("irq2_vec", bus.trap_vec, 32'h108);
        bus.int_en = 0;
        step(1);
        chk("irq2_withdraw", 32'(bus.trap_req), 0);
        bus.INT = 0; bus.int_en = 1;
        step(4);
        // IRQ3 request preempted by NMI
        bus.INT = 1; bus.INT_NUM = 3;
        step(3);
        chk("irq3_vec", bus.trap_vec, 32'h10C);
        bus.NMI = 1;
        step(3);
        chk("irq3_hold", bus.trap_vec, 32'h10C);
        step(1);
        chk("nmi_pre_vec", bus.trap_vec, 32'h80);
        chk("nmi_pre_cause", 32'(bus.trap_cause), 32'hF);
        chk("nmi_pre_svc", 32'(bus.in_service), 0);
        bus.NMI = 0;
        ack();
        chk("nmi_pre_act", 32'(bus.nmi_active), 1);
        ret();
        chk("nmi_pre_idle", 32'(bus.trap_req), 0);
        step(1);
        chk("irq3_rereq", 32'(bus.trap_req), 1);
        chk("irq3_revec", bus.trap_vec, 32'h10C);
        bus.INT = 0;
        ack();
        step(3);
        ret();
        step(2);
        // NMI nested over IRQ7 handler
        bus.INT = 1; bus.INT_NUM = 7;
        step(3);
        chk("irq7_vec", bus.trap_vec, 32'h11C);
        chk("irq7_cause", 32'(bus.trap_cause), 7);
        bus.INT = 0;
        ack();
        step(3);
        bus.NMI = 1;
        step(4);
        chk("nest_req", 32'(bus.trap_req), 1);
        chk("nest_vec", bus.trap_vec, 32'h80);
        chk("nest_svc", 32'(bus.in_service), 1);
        bus.NMI = 0;
        ack();
        chk("nest_act", 32'(bus.nmi_active), 1);
        ret();
        chk("nest_back_act", 32'(bus.nmi_active), 0);
        chk("nest_back_svc", 32'(bus.in_service), 1);
        chk("nest_back_req", 32'(bus.trap_req), 0);
        ret();
        chk("nest_done", 32'(bus.in_service), 0);
        step(2);
        // second NMI edge during NMI handler
        bus.NMI = 1;
        step(4);
        chk("nmi2_first", 32'(bus.trap_req), 1);
        bus.NMI = 0;
        ack();
        step(3);
        bus.NMI = 1;
        step(4);
        bus.NMI = 0;
        ret();
        chk("nmi2_rereq", 32'(bus.trap_req), 1);
        chk("nmi2_vec", bus.trap_vec, 32'h80);
        ack();
        ret();
        chk("nmi2_idle", 32'(bus.in_service), 0);
        step(3);
        // trap_ret in SVC coinciding with the registered NMI edge
        bus.INT = 1; bus.INT_NUM = 4;
        step(3);
        chk("irq4_vec", bus.trap_vec, 32'h110);
        bus.INT = 0;
        ack();
        step(3);
        bus.NMI = 1;
        step(2);
        ret();
        chk("coinc_idle_req", 32'(bus.trap_req), 0);
        chk("coinc_idle_svc", 32'(bus.in_service), 0);
        step(1);
        chk("coinc_nmi_vec", bus.trap_vec, 32'h80);
        bus.NMI = 0;
        ack();
        ret();
        step(3);
        // async reset mid-REQ
        bus.INT = 1; bus.INT_NUM = 1;
        step(3);
        chk("irq1_vec", bus.trap_vec, 32'h104);
        rst = 0; bus.INT = 0;
        #1;
        chk("arst_req", 32'(bus.trap_req), 0);
        chk("arst_vec", bus.trap_vec, 0);
        step(2);
        rst = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            seen |= bus.trap_req;
        end
        chk("arst_quiet", 32'(seen), 0);
        // async reset mid-NMI_SVC with another NMI pending
        bus.NMI = 1;
        step(4);
        bus.NMI = 0;
        ack();
        chk("svc2_act", 32'(bus.nmi_active), 1);
        step(3);
        bus.NMI = 1;
        step(4);
        rst = 0; bus.NMI = 0;
        #1;
        chk("arst2_act", 32'(bus.nmi_active), 0);
        chk("arst2_svc", 32'(bus.in_service), 0);
        step(2);
        rst = 1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            seen |= bus.trap_req;
        end
        chk("arst2_quiet", 32'(seen), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
